// File: rtl/multicycle_control.sv
// Multi-cycle RV32I main control FSM.
// Sequences FETCH/DECODE/EXEC/MEM/WB for each instruction and drives the datapath
// strobes. Memory accesses complete either on a ready handshake or after a fixed
// latency. Long waits trap on timeout, stall freezes the FSM, and illegal opcodes
// trap. TRAP can only be left through reset.
module multicycle_control #(
  parameter int unsigned MEM_HANDSHAKE = 1,
  parameter int unsigned MEM_LAT       = 2,
  parameter int unsigned TIMEOUT       = 64,
  parameter int unsigned CNT_W         = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       branch_taken,
  input  logic       mem_ready,
  input  logic       stall,
  output logic [2:0] state,
  output logic       mem_req,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_sel,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_write,
  output logic [1:0] mem_to_reg,
  output logic       instr_retired,
  output logic       illegal_instr,
  output logic       mem_timeout
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(MEM_LAT - 1);
  localparam logic [CNT_W-1:0] TO_LIM   = CNT_W'(TIMEOUT);

  state_e           state_q, state_d;
  logic [6:0]       op_q, op_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             illegal_q, illegal_d;
  logic             timeout_q, timeout_d;

  // Raw strobes before the stall and reset gating
  logic       r_mem_req, r_mem_read, r_mem_write, r_ir_write, r_pc_write;
  logic       r_reg_write, r_retired;
  logic [1:0] r_pc_sel, r_src_a, r_src_b, r_alu_op, r_mem_to_reg;

  // Opcode classes of the latched instruction
  logic is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr;
  logic op_legal, mem_done, timeout_hit;

  // Classify the latched opcode and evaluate the done and timeout conditions
  always_comb begin
    is_r    = (op_q == OP_R);
    is_i    = (op_q == OP_I);
    is_ld   = (op_q == OP_LD);
    is_st   = (op_q == OP_ST);
    is_br   = (op_q == OP_BR);
    is_jal  = (op_q == OP_JAL);
    is_jalr = (op_q == OP_JALR);
    op_legal = (opcode == OP_R)  || (opcode == OP_I)  || (opcode == OP_LD) ||
               (opcode == OP_ST) || (opcode == OP_BR) || (opcode == OP_JAL) ||
               (opcode == OP_JALR);
    // In fixed-latency mode, the wait counter alone determines when the access is done
    mem_done = (MEM_HANDSHAKE != 0) ? mem_ready : (wait_cnt_q == LAT_LAST);
    // Done takes priority when it coincides with the timeout
    timeout_hit = (TIMEOUT != 0) && (wait_cnt_q >= TO_LIM) && !mem_done;
  end

  // Next state, counters and raw strobes
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    wait_cnt_d   = wait_cnt_q;
    illegal_d    = illegal_q;
    timeout_d    = timeout_q;
    r_mem_req    = 1'b0;
    r_mem_read   = 1'b0;
    r_mem_write  = 1'b0;
    r_ir_write   = 1'b0;
    r_pc_write   = 1'b0;
    r_reg_write  = 1'b0;
    r_retired    = 1'b0;
    r_pc_sel     = 2'b00;
    r_src_a      = 2'b00;
    r_src_b      = 2'b00;
    r_alu_op     = 2'b00;
    r_mem_to_reg = 2'b00;

    unique case (state_q)
      S_FETCH: begin
        r_mem_req  = 1'b1;
        r_mem_read = 1'b1;
        r_src_a    = 2'b01;
        r_src_b    = 2'b10;
        if (mem_done) begin
          r_ir_write = 1'b1;
          r_pc_write = 1'b1;
          state_d    = S_DECODE;
        end else if (timeout_hit) begin
          r_mem_req  = 1'b0;
          r_mem_read = 1'b0;
          timeout_d  = 1'b1;
          state_d    = S_TRAP;
        end else begin
          wait_cnt_d = (wait_cnt_q == CNT_MAX) ? CNT_MAX : wait_cnt_q + 1'b1;
        end
      end
      S_DECODE: begin
        op_d = opcode;
        if (op_legal) begin
          state_d = S_EXEC;
        end else begin
          illegal_d = 1'b1;
          state_d   = S_TRAP;
        end
      end
      S_EXEC: begin
        if (is_r) begin
          r_alu_op = 2'b10;
          state_d  = S_WB;
        end else if (is_i) begin
          r_alu_op = 2'b11;
          r_src_b  = 2'b01;
          state_d  = S_WB;
        end else if (is_ld || is_st) begin
          r_src_b = 2'b01;
          state_d = S_MEM;
        end else if (is_br) begin
          r_alu_op   = 2'b01;
          r_pc_write = branch_taken;
          r_pc_sel   = 2'b01;
          r_retired  = 1'b1;
          state_d    = S_FETCH;
        end else if (is_jal) begin
          r_pc_write = 1'b1;
          r_pc_sel   = 2'b01;
          state_d    = S_WB;
        end else if (is_jalr) begin
          r_pc_write = 1'b1;
          r_pc_sel   = 2'b10;
          state_d    = S_WB;
        end else begin
          // Unreachable because DECODE filters illegal opcodes; handled defensively
          state_d = S_TRAP;
        end
      end
      S_MEM: begin
        r_mem_req   = 1'b1;
        r_mem_read  = is_ld;
        r_mem_write = is_st;
        if (mem_done) begin
          if (is_ld) begin
            state_d = S_WB;
          end else begin
            r_retired = 1'b1;
            state_d   = S_FETCH;
          end
        end else if (timeout_hit) begin
          r_mem_req   = 1'b0;
          r_mem_read  = 1'b0;
          r_mem_write = 1'b0;
          timeout_d   = 1'b1;
          state_d     = S_TRAP;
        end else begin
          wait_cnt_d = (wait_cnt_q == CNT_MAX) ? CNT_MAX : wait_cnt_q + 1'b1;
        end
      end
      S_WB: begin
        r_reg_write  = 1'b1;
        r_retired    = 1'b1;
        r_mem_to_reg = is_ld ? 2'b01 : ((is_jal || is_jalr) ? 2'b10 : 2'b00);
        state_d      = S_FETCH;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    // Each state starts with a fresh wait count
    if (state_d != state_q) wait_cnt_d = '0;

    // A stall freezes all FSM state. Strobes are suppressed so that no side effect repeats
    if (stall) begin
      state_d     = state_q;
      op_d        = op_q;
      wait_cnt_d  = wait_cnt_q;
      illegal_d   = illegal_q;
      timeout_d   = timeout_q;
      r_mem_req   = 1'b0;
      r_mem_read  = 1'b0;
      r_mem_write = 1'b0;
      r_ir_write  = 1'b0;
      r_pc_write  = 1'b0;
      r_reg_write = 1'b0;
      r_retired   = 1'b0;
    end
  end

  // Drive the outputs. While reset is asserted, every output is held at zero
  always_comb begin
    state         = 3'd0;
    mem_req       = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_sel        = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    reg_write     = 1'b0;
    mem_to_reg    = 2'b00;
    instr_retired = 1'b0;
    illegal_instr = 1'b0;
    mem_timeout   = 1'b0;
    if (!reset) begin
      state         = state_q;
      mem_req       = r_mem_req;
      mem_read      = r_mem_read;
      mem_write     = r_mem_write;
      ir_write      = r_ir_write;
      pc_write      = r_pc_write;
      pc_sel        = r_pc_sel;
      alu_src_a     = r_src_a;
      alu_src_b     = r_src_b;
      alu_op        = r_alu_op;
      reg_write     = r_reg_write;
      mem_to_reg    = r_mem_to_reg;
      instr_retired = r_retired;
      illegal_instr = illegal_q;
      mem_timeout   = timeout_q;
    end
  end

  // State register, latched opcode, wait counter and sticky flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_FETCH;
      op_q       <= '0;
      wait_cnt_q <= '0;
      illegal_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      wait_cnt_q <= wait_cnt_d;
      illegal_q  <= illegal_d;
      timeout_q  <= timeout_d;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control. The main instance runs in handshake mode
// with TIMEOUT=8, and a second instance checks fixed-latency fetch with MEM_LAT=3.
module tb_multicycle_control;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, reset2, stall, mem_ready, branch_taken;
  logic [6:0] opcode, opcode2;

  logic [2:0] state, state2;
  logic       mem_req, mem_read, mem_write, ir_write, pc_write, reg_write;
  logic       instr_retired, illegal_instr, mem_timeout;
  logic [1:0] pc_sel, alu_src_a, alu_src_b, alu_op, mem_to_reg;
  logic       mem_req2, mem_read2, mem_write2, ir_write2, pc_write2, reg_write2;
  logic       instr_retired2, illegal_instr2, mem_timeout2;
  logic [1:0] pc_sel2, alu_src_a2, alu_src_b2, alu_op2, mem_to_reg2;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  multicycle_control #(.MEM_HANDSHAKE(1), .MEM_LAT(2), .TIMEOUT(8), .CNT_W(8)) u_dut (
    .clk(clk), .reset(reset), .opcode(opcode), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .stall(stall), .state(state), .mem_req(mem_req),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .pc_write(pc_write), .pc_sel(pc_sel), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .instr_retired(instr_retired),
    .illegal_instr(illegal_instr), .mem_timeout(mem_timeout)
  );

  multicycle_control #(.MEM_HANDSHAKE(0), .MEM_LAT(3), .TIMEOUT(64), .CNT_W(8)) u_dut_fix (
    .clk(clk), .reset(reset2), .opcode(opcode2), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .stall(1'b0), .state(state2), .mem_req(mem_req2),
    .mem_read(mem_read2), .mem_write(mem_write2), .ir_write(ir_write2),
    .pc_write(pc_write2), .pc_sel(pc_sel2), .alu_src_a(alu_src_a2),
    .alu_src_b(alu_src_b2), .alu_op(alu_op2), .reg_write(reg_write2),
    .mem_to_reg(mem_to_reg2), .instr_retired(instr_retired2),
    .illegal_instr(illegal_instr2), .mem_timeout(mem_timeout2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("miscompare on %s", tag);
    end
  endtask

  initial begin
    reset = 1'b1; reset2 = 1'b1; stall = 1'b0; mem_ready = 1'b0;
    branch_taken = 1'b0; opcode = 7'd0; opcode2 = OP_R;
    tick(); tick();

    // Outputs stay at zero during reset, even with mem_ready asserted
    mem_ready = 1'b1; #1;
    chk("rst_state", state, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_ir_write", ir_write, 0);
    chk("rst_illegal", illegal_instr, 0);
    chk("rst_timeout", mem_timeout, 0);

    // R-type with zero wait states: 0,1,2,4,0
    reset = 1'b0; opcode = OP_R; #1;
    chk("r_f_state", state, 0);
    chk("r_f_ir_write", ir_write, 1);
    chk("r_f_pc_write", pc_write, 1);
    chk("r_f_src_a", alu_src_a, 1);
    chk("r_f_src_b", alu_src_b, 2);
    tick(); chk("r_d_state", state, 1);
    tick(); chk("r_e_state", state, 2); chk("r_e_alu_op", alu_op, 2); chk("r_e_src_b", alu_src_b, 0);
    tick(); chk("r_wb_state", state, 4); chk("r_wb_reg_write", reg_write, 1);
    chk("r_wb_retired", instr_retired, 1); chk("r_wb_m2r", mem_to_reg, 0);
    tick(); chk("r_back_state", state, 0);

    // Load with ready delayed three cycles in MEM
    opcode = OP_LD;
    tick(); tick(); #1;
    chk("ld_e_state", state, 2); chk("ld_e_src_b", alu_src_b, 1); chk("ld_e_alu_op", alu_op, 0);
    tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("ld_m_state", state, 3); chk("ld_m_req", mem_req, 1); chk("ld_m_read", mem_read, 1);
      tick();
    end
    mem_ready = 1'b1; #1;
    chk("ld_m_done_state", state, 3); chk("ld_m_done_req", mem_req, 1);
    tick(); chk("ld_wb_state", state, 4); chk("ld_wb_m2r", mem_to_reg, 1); chk("ld_wb_reg_write", reg_write, 1);
    tick(); chk("ld_back_state", state, 0);

    // Branch taken, then not taken
    opcode = OP_BR; branch_taken = 1'b1;
    tick(); tick(); #1;
    chk("br_t_state", state, 2); chk("br_t_pc_write", pc_write, 1); chk("br_t_pc_sel", pc_sel, 1);
    chk("br_t_retired", instr_retired, 1); chk("br_t_reg_write", reg_write, 0); chk("br_t_alu_op", alu_op, 1);
    tick(); chk("br_t_back", state, 0);
    branch_taken = 1'b0;
    tick(); tick(); #1;
    chk("br_n_pc_write", pc_write, 0); chk("br_n_retired", instr_retired, 1);
    tick(); chk("br_n_back", state, 0);

    // JAL and JALR
    opcode = OP_JAL;
    tick(); tick(); #1;
    chk("jal_e_pc_write", pc_write, 1); chk("jal_e_pc_sel", pc_sel, 1);
    tick(); chk("jal_wb_m2r", mem_to_reg, 2); chk("jal_wb_reg_write", reg_write, 1);
    tick();
    opcode = OP_JALR;
    tick(); tick(); #1;
    chk("jalr_e_pc_sel", pc_sel, 2);
    tick(); chk("jalr_wb_m2r", mem_to_reg, 2);
    tick(); chk("jalr_back", state, 0);

    // Store with a five-cycle stall in MEM. The wait count must hold during the stall
    opcode = OP_ST;
    tick(); tick(); tick();
    mem_ready = 1'b0; #1;
    chk("st_m_state", state, 3); chk("st_m_write", mem_write, 1); chk("st_m_read", mem_read, 0);
    tick();
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("st_stall_state", state, 3); chk("st_stall_req", mem_req, 0);
      tick();
    end
    stall = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("st_wait_state", state, 3); chk("st_wait_req", mem_req, 1);
      tick();
    end
    mem_ready = 1'b1; #1;
    chk("st_done_state", state, 3); chk("st_done_retired", instr_retired, 1);
    tick(); chk("st_back", state, 0);

    // Reset asserted in WB suppresses reg_write
    opcode = OP_R;
    tick(); tick(); tick();
    chk("wbr_pre_state", state, 4);
    reset = 1'b1; #1;
    chk("wbr_reg_write", reg_write, 0); chk("wbr_retired", instr_retired, 0); chk("wbr_state", state, 0);
    tick();
    reset = 1'b0; #1;
    chk("wbr_post_state", state, 0); chk("wbr_post_reg_write", reg_write, 0);

    // Fetch timeout after eight wait cycles
    mem_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("to_wait_state", state, 0); chk("to_wait_req", mem_req, 1);
      tick();
    end
    #1;
    chk("to_hit_req", mem_req, 0); chk("to_hit_flag_pre", mem_timeout, 0);
    tick(); chk("to_trap_state", state, 5); chk("to_flag", mem_timeout, 1); chk("to_trap_req", mem_req, 0);
    tick(); chk("to_trap_hold", state, 5);
    reset = 1'b1; tick();
    reset = 1'b0; mem_ready = 1'b1; opcode = 7'd0; #1;
    chk("to_clr_flag", mem_timeout, 0); chk("to_clr_state", state, 0);

    // Illegal opcode traps and holds TRAP until reset
    tick(); chk("ill_d_state", state, 1);
    tick();
    for (int i = 0; i < 20; i++) begin
      #1;
      chk("ill_state", state, 5); chk("ill_flag", illegal_instr, 1); chk("ill_req", mem_req, 0);
      tick();
    end
    reset = 1'b1; tick();
    reset = 1'b0; #1;
    chk("ill_clr_state", state, 0); chk("ill_clr_flag", illegal_instr, 0);

    // Fixed latency of three cycles. mem_ready is ignored in this mode
    mem_ready = 1'b0; reset2 = 1'b0; #1;
    chk("fx_c0_state", state2, 0); chk("fx_c0_ir_write", ir_write2, 0); chk("fx_c0_req", mem_req2, 1);
    tick(); chk("fx_c1_ir_write", ir_write2, 0);
    tick(); chk("fx_c2_ir_write", ir_write2, 1); chk("fx_c2_state", state2, 0);
    tick(); chk("fx_decode_state", state2, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
